// File: rtl/icache_nway_if.sv
// CPU-fetch and refill-side signals of icache_nway bundled together.
// slave: the cache's own view; master: the IF stage plus AXI read bridge around it.
// Widths are fixed at 32 bits, independent of the cache geometry.
interface icache_nway_if;
    logic [31:0] addr;
    logic        rd_req;
    logic        flush;
    logic        miss;
    logic [31:0] rd_data;
    logic        mem_read_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  addr, rd_req, flush, mem_rvalid, mem_rdata,
        output miss, rd_data, mem_read_req, mem_addr
    );

    modport master (
        output addr, rd_req, flush, mem_rvalid, mem_rdata,
        input  miss, rd_data, mem_read_req, mem_addr
    );
endinterface

// File: rtl/icache_nway.sv
// N-way set-associative read-only I-cache, tree pseudo-LRU, word-serial line refill.
// Hit: same cycle; miss with zero-wait memory: 1 + WORDS + 1 stall cycles, then hit.
// Stalls the CPU via miss; memory beats are consumed whenever mem_rvalid is high in REFILL.
// Optional macro ICACHE_STAT_EN adds saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module icache_nway #(
    parameter int OFFSET_LEN = 5,
    parameter int INDEX_LEN  = 7,
    parameter int WAY_CNT    = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    icache_nway_if.slave ic
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
`endif
);

    localparam int WORD_W  = OFFSET_LEN - 2;
    localparam int WORDS   = 1 << WORD_W;
    localparam int SETS    = 1 << INDEX_LEN;
    localparam int TAG_LEN = 32 - INDEX_LEN - OFFSET_LEN;
    localparam int WAY_W   = $clog2(WAY_CNT);
    localparam int PLRU_W  = WAY_CNT - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_COMMIT
    } state_t;

    // Storage: RAM-like arrays with no reset, plus flop-based valid/PLRU state.
    logic [TAG_LEN-1:0] tag_mem  [WAY_CNT][SETS];
    logic [31:0]        data_mem [WAY_CNT][SETS][WORDS];
    logic [SETS-1:0][WAY_CNT-1:0] valid_q;
    logic [SETS-1:0][PLRU_W-1:0]  plru_q;

    // Refill context
    state_t             state_q, state_d;
    logic [WORD_W-1:0]  beat_q, beat_d;
    logic [31:0]        line_addr_q, line_addr_d;
    logic [INDEX_LEN-1:0] idx_q, idx_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic               flush_pend_q, flush_pend_d;
    logic [31:0]        line_buf_q [WORDS];

    // Lookup
    logic [INDEX_LEN-1:0] req_idx;
    logic [TAG_LEN-1:0]   req_tag;
    logic [WORD_W-1:0]    req_word;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     fill_way;
    logic                 idle_hit;
    logic                 start_refill;
    logic                 commit_flush;
    logic                 unused_addr_bits;

    // Walk the tree from the root following node bits (0 = left) to the victim leaf.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        int               node;
        logic             b;
        logic [WAY_W-1:0] way;
        node = 0;
        way  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            b = bits[node];
            way[WAY_W-1-l] = b;
            node = 2 * node + (b ? 2 : 1);
        end
        return way;
    endfunction

    // Point every node on the accessed way's path at the opposite subtree.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        int                node;
        logic              dir;
        logic [PLRU_W-1:0] nb;
        node = 0;
        nb   = bits;
        for (int l = 0; l < WAY_W; l++) begin
            dir = way[WAY_W-1-l];
            nb[node] = ~dir;
            node = 2 * node + (dir ? 2 : 1);
        end
        return nb;
    endfunction

    assign req_idx  = ic.addr[OFFSET_LEN+INDEX_LEN-1:OFFSET_LEN];
    assign req_tag  = ic.addr[31:32-TAG_LEN];
    assign req_word = ic.addr[OFFSET_LEN-1:2];
    // Byte-within-word bits never matter for a word-wide fetch.
    assign unused_addr_bits = ^ic.addr[1:0];

    // Tag compare across all ways; lowest way wins should duplicates ever exist.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAY_CNT - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_mem[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim choice: lowest-numbered invalid way, else the PLRU leaf.
    always_comb begin
        fill_way = plru_victim(plru_q[req_idx]);
        for (int w = WAY_CNT - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                fill_way = WAY_W'(w);
            end
        end
    end

    assign idle_hit     = (state_q == S_IDLE) && ic.rd_req && hit && !ic.flush;
    assign start_refill = (state_q == S_IDLE) && ic.rd_req && !hit && !ic.flush;
    assign commit_flush = flush_pend_q || ic.flush;

    assign ic.rd_data      = hit ? data_mem[hit_way][req_idx][req_word] : 32'h0;
    assign ic.miss         = ic.rd_req && !((state_q == S_IDLE) && hit && !ic.flush);
    assign ic.mem_read_req = (state_q == S_REFILL);
    assign ic.mem_addr     = line_addr_q;

    // Next-state logic for the refill sequencer.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        line_addr_d  = line_addr_q;
        idx_d        = idx_q;
        victim_d     = victim_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            S_IDLE: begin
                if (start_refill) begin
                    state_d     = S_REFILL;
                    line_addr_d = {ic.addr[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
                    idx_d       = req_idx;
                    victim_d    = fill_way;
                    beat_d      = '0;
                end
            end
            S_REFILL: begin
                if (ic.flush) begin
                    flush_pend_d = 1'b1;
                end
                if (ic.mem_rvalid) begin
                    // Wraps to zero on the last beat, ready for the next burst.
                    beat_d = beat_q + 1'b1;
                    if (beat_q == WORD_W'(WORDS - 1)) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                flush_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and refill-context registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            line_addr_q  <= '0;
            idx_q        <= '0;
            victim_q     <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            line_addr_q  <= line_addr_d;
            idx_q        <= idx_d;
            victim_q     <= victim_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Valid and PLRU maintenance: flush clears, hits and commits mark MRU.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            plru_q  <= '0;
        end else if ((state_q == S_IDLE) && ic.flush) begin
            valid_q <= '0;
            plru_q  <= '0;
        end else if (idle_hit) begin
            plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
        end else if (state_q == S_COMMIT) begin
            if (commit_flush) begin
                valid_q <= '0;
                plru_q  <= '0;
            end else begin
                valid_q[idx_q][victim_q] <= 1'b1;
                plru_q[idx_q]            <= plru_touch(plru_q[idx_q], victim_q);
            end
        end
    end

    // Collect refill beats in arrival order; a partial line is simply abandoned.
    always_ff @(posedge clk_i) begin
        if ((state_q == S_REFILL) && ic.mem_rvalid) begin
            line_buf_q[beat_q] <= ic.mem_rdata;
        end
    end

    // Install the completed line into the victim way unless a flush intervened.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_q == S_COMMIT) && !commit_flush) begin
            tag_mem[victim_q][idx_q] <= line_addr_q[31:32-TAG_LEN];
            for (int w = 0; w < WORDS; w++) begin
                data_mem[victim_q][idx_q][w] <= line_buf_q[w];
            end
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating event counters; only reset clears them, flush does not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (idle_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (start_refill && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Scoreboarded bench for icache_nway with default geometry (4 ways, 8-word lines).
// A behavioural memory answers refills; expected words come from the same address map.
module tb_icache_nway;

    logic clk = 1'b0;
    logic rst = 1'b1;

    icache_nway_if ifc ();

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_nway dut (
        .clk_i (clk),
        .rst_i (rst),
        .ic    (ifc)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cycles;
        int          refills;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Memory model state
    int          refills = 0;
    int          beats = 0;
    int          mbeat = 0;
    logic [31:0] last_mem_addr = 32'h0;
    bit          mem_wait_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Backing-store contents: for line 0x1000 the beats are 0x10..0x17.
    function automatic logic [31:0] mem_word(input logic [31:0] line, input int beat);
        logic [31:0] l;
        l = line & 32'hFFFF_FFE0;
        return ((l >> 8) + 32'(beat)) ^ {8'h0, l[7:0], 16'h0};
    endfunction

    // Refill responder: one beat per cycle while requested, optional random gaps.
    initial begin
        ifc.mem_rvalid = 1'b0;
        ifc.mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (ifc.mem_read_req) begin
                if (mem_wait_en && ($urandom_range(0, 2) == 0)) begin
                    ifc.mem_rvalid = 1'b0;
                end else begin
                    if (mbeat == 0) begin
                        refills++;
                        last_mem_addr = ifc.mem_addr;
                    end
                    ifc.mem_rvalid = 1'b1;
                    ifc.mem_rdata  = mem_word(ifc.mem_addr, mbeat);
                    mbeat++;
                    beats++;
                end
            end else begin
                ifc.mem_rvalid = 1'b0;
                mbeat = 0;
            end
        end
    end

    // Issue one fetch starting at a negedge; flush is pulsed in stall cycle flush_at (-1: never).
    // cyc < 0 skips the stall-length check (random memory gaps).
    task automatic fetch(input logic [31:0] a, input int cyc, input int nref, input int flush_at);
        int   n;
        int   r0;
        exp_t e;
        exp_q.push_back('{addr: a, data: mem_word(a, int'((a >> 2) & 32'h7)),
                          cycles: cyc, refills: nref});
        r0 = refills;
        ifc.addr   = a;
        ifc.rd_req = 1'b1;
        ifc.flush  = (flush_at == 0);
        n = 0;
        #1;
        while (ifc.miss && (n < 400)) begin
            @(negedge clk);
            n++;
            ifc.flush = (n == flush_at);
            #1;
        end
        ifc.flush = 1'b0;
        e = exp_q.pop_front();
        check("miss_settle", ifc.miss, 1'b0);
        check("rd_data", ifc.rd_data, e.data);
        if (e.cycles >= 0) check("miss_cycles", n, e.cycles);
        check("refill_count", refills - r0, e.refills);
        if (e.refills > 0) check("mem_addr", last_mem_addr, e.addr & 32'hFFFF_FFE0);
        @(negedge clk);
        ifc.rd_req = 1'b0;
    endtask

    task automatic flush_pulse();
        ifc.rd_req = 1'b0;
        ifc.flush  = 1'b1;
        @(negedge clk);
        ifc.flush  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0;
        int b0;
        int n;
        ifc.addr   = 32'h0;
        ifc.rd_req = 1'b0;
        ifc.flush  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_miss", ifc.miss, 1'b0);
        check("rst_rd_data", ifc.rd_data, 32'h0);
        check("rst_mem_read_req", ifc.mem_read_req, 1'b0);
        check("rst_mem_addr", ifc.mem_addr, 32'h0);
        ifc.rd_req = 1'b1;
        ifc.addr   = 32'h0000_1004;
        #1;
        check("rst_miss_follows_req", ifc.miss, 1'b1);
        ifc.rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Cold miss then same-line hit.
        fetch(32'h0000_1004, 10, 1, -1);
        fetch(32'h0000_101C, 0, 0, -1);

        // rd_req low never starts a refill.
        ifc.addr = 32'h0000_6000;
        r0 = refills;
        repeat (4) @(negedge clk);
        #1;
        check("idle_no_req_miss", ifc.miss, 1'b0);
        check("idle_no_req_refill", refills - r0, 0);
        check("idle_no_req_mem_read_req", ifc.mem_read_req, 1'b0);
        @(negedge clk);

        // Flush in IDLE, then the same address refills fully.
        flush_pulse();
        fetch(32'h0000_1004, 10, 1, -1);
        // Flush together with a request to a resident line: one flush cycle, then a refill.
        fetch(32'h0000_1004, 11, 1, 0);
        // Flush mid-burst: burst drains, nothing installed, the lookup refills again.
        b0 = beats;
        fetch(32'h0000_1048, 20, 2, 3);
        check("flush_mid_beats", beats - b0, 16);

        // PLRU: fill A..D in set 0. After hitting A, the tree points at the C/D half;
        // touching D as well steers the victim back to B, the least recently used line.
        flush_pulse();
        fetch(32'h0000_1000, 10, 1, -1);
        fetch(32'h0000_2000, 10, 1, -1);
        fetch(32'h0000_3000, 10, 1, -1);
        fetch(32'h0000_4000, 10, 1, -1);
        fetch(32'h0000_1008, 0, 0, -1);
        fetch(32'h0000_400C, 0, 0, -1);
        fetch(32'h0000_5004, 10, 1, -1);
        fetch(32'h0000_1010, 0, 0, -1);
        fetch(32'h0000_3014, 0, 0, -1);
        fetch(32'h0000_4018, 0, 0, -1);
        fetch(32'h0000_2004, 10, 1, -1);

        // Memory with random wait states, then a hit on the filled line.
        mem_wait_en = 1'b1;
        fetch(32'h0000_2468, -1, 1, -1);
        mem_wait_en = 1'b0;
        fetch(32'h0000_2470, 0, 0, -1);

        // Reset after three accepted beats.
        b0 = beats;
        ifc.addr   = 32'h0000_3A44;
        ifc.rd_req = 1'b1;
        n = 0;
        #1;
        while (((beats - b0) < 3) && (n < 50)) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_mid_beats", beats - b0, 3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_mem_read_req", ifc.mem_read_req, 1'b0);
        check("rst_mid_miss", ifc.miss, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        b0 = beats;
        fetch(32'h0000_3A44, 10, 1, -1);
        check("rst_refetch_beats", beats - b0, 8);

`ifdef ICACHE_STAT_EN
        // The refetch above was one refill plus its hit cycle; four more hits make five.
        fetch(32'h0000_3A40, 0, 0, -1);
        fetch(32'h0000_3A48, 0, 0, -1);
        fetch(32'h0000_3A50, 0, 0, -1);
        fetch(32'h0000_3A5C, 0, 0, -1);
        #1;
        check("stat_miss_cnt", miss_cnt, 32'd1);
        check("stat_hit_cnt", hit_cnt, 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
